// File: rtl/mkio_transmitter.sv
// MIL-STD-1553 word transmitter: 3-bit-time sync, 16 data bits MSB-first and odd parity,
// Manchester II encoded with a one-word holding register. Optional fail-safe: MKIO_TX_FAILSAFE_EN.
module mkio_transmitter #(
    parameter int unsigned HALF_BIT  = 8,
    parameter int unsigned MAX_WORDS = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_ready,
    input  logic [15:0] tx_data,
    input  logic        tx_cd,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        tx_ovf,
    output logic        tx_fail,
    output logic        tx_p,
    output logic        tx_n
);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    localparam logic [7:0] HcntLast = 8'(HALF_BIT - 1);
    localparam logic [5:0] HbLast   = 6'd39;

    state_e      state;
    logic [16:0] shift_word;
    logic [16:0] hold_word;
    logic        hold_full;
    logic [5:0]  hb;
    logic [7:0]  hcnt;
    logic        fail;

    logic [16:0] new_word;
    logic        half_end;
    logic        limit_hit;
    logic        next_lvl;
    logic        new_lvl0;
    logic        hold_lvl0;

    // Line level for half-bit h of word w = {cd, data}; a 1 is sent high-then-low.
    function automatic logic line_level(input logic [16:0] w, input logic [5:0] h);
        logic [5:0] d;
        logic [3:0] idx;
        logic       b;
        d   = h - 6'd6;
        idx = 4'd15 - d[4:1];
        if (h < 6'd3) begin
            b = ~w[16];
        end else if (h < 6'd6) begin
            b = w[16];
        end else if (h < 6'd38) begin
            b = h[0] ? ~w[idx] : w[idx];
        end else begin
            b = h[0] ? ^w[15:0] : ~^w[15:0];
        end
        return b;
    endfunction

    assign new_word  = {tx_cd, tx_data};
    assign half_end  = (hcnt == HcntLast);
    assign next_lvl  = line_level(shift_word, hb + 6'd1);
    assign new_lvl0  = line_level(new_word, 6'd0);
    assign hold_lvl0 = line_level(hold_word, 6'd0);

`ifdef MKIO_TX_FAILSAFE_EN
    localparam int unsigned CntW = $clog2(MAX_WORDS + 1);
    logic [CntW-1:0] word_cnt;
    assign limit_hit = (word_cnt == CntW'(MAX_WORDS));
`else
    assign limit_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            shift_word <= '0;
            hold_word  <= '0;
            hold_full  <= 1'b0;
            hb         <= '0;
            hcnt       <= '0;
            tx_p       <= 1'b0;
            tx_n       <= 1'b0;
            tx_done    <= 1'b0;
            tx_ovf     <= 1'b0;
            fail       <= 1'b0;
`ifdef MKIO_TX_FAILSAFE_EN
            word_cnt   <= '0;
`endif
        end else begin
            tx_done <= 1'b0;
            tx_ovf  <= 1'b0;
            unique case (state)
                StIdle: begin
                    tx_p <= 1'b0;
                    tx_n <= 1'b0;
`ifdef MKIO_TX_FAILSAFE_EN
                    word_cnt <= '0;
`endif
                    if (tx_ready) begin
                        if (fail) begin
                            tx_ovf <= 1'b1;
                        end else begin
                            state      <= StSend;
                            shift_word <= new_word;
                            hb         <= '0;
                            hcnt       <= '0;
                            tx_p       <= new_lvl0;
                            tx_n       <= ~new_lvl0;
`ifdef MKIO_TX_FAILSAFE_EN
                            word_cnt   <= CntW'(1);
`endif
                        end
                    end
                end
                StSend: begin
                    hcnt <= half_end ? 8'd0 : hcnt + 8'd1;
                    if (half_end && hb == HbLast) begin
                        tx_done <= 1'b1;
                        hb      <= '0;
                        if ((hold_full || tx_ready) && limit_hit) begin
                            // Fail-safe trip: drop everything and latch the fault.
                            state     <= StIdle;
                            hold_full <= 1'b0;
                            fail      <= 1'b1;
                            tx_p      <= 1'b0;
                            tx_n      <= 1'b0;
                            tx_ovf    <= tx_ready;
                        end else if (hold_full) begin
                            shift_word <= hold_word;
                            tx_p       <= hold_lvl0;
                            tx_n       <= ~hold_lvl0;
                            hold_full  <= tx_ready;
                            if (tx_ready) begin
                                hold_word <= new_word;
                            end
`ifdef MKIO_TX_FAILSAFE_EN
                            word_cnt <= word_cnt + 1'b1;
`endif
                        end else if (tx_ready) begin
                            // Strobe on the final clock chains straight on with no gap.
                            shift_word <= new_word;
                            tx_p       <= new_lvl0;
                            tx_n       <= ~new_lvl0;
`ifdef MKIO_TX_FAILSAFE_EN
                            word_cnt <= word_cnt + 1'b1;
`endif
                        end else begin
                            state <= StIdle;
                            tx_p  <= 1'b0;
                            tx_n  <= 1'b0;
                        end
                    end else begin
                        if (half_end) begin
                            hb   <= hb + 6'd1;
                            tx_p <= next_lvl;
                            tx_n <= ~next_lvl;
                        end
                        if (tx_ready) begin
                            if (hold_full) begin
                                tx_ovf <= 1'b1;
                            end else begin
                                hold_word <= new_word;
                                hold_full <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign tx_busy = (state == StSend) | hold_full;
    assign tx_fail = fail;

endmodule

// File: tb/tb_mkio_transmitter.sv
// Directed bench for mkio_transmitter with HALF_BIT=4: decodes captured line samples per word.
module tb_mkio_transmitter;

    localparam int H    = 4;
    localparam int NMAX = 6000;

    localparam int SigP    = 0;
    localparam int SigN    = 1;
    localparam int SigDone = 2;
    localparam int SigBusy = 3;
    localparam int SigOvf  = 4;
    localparam int SigFail = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tx_ready = 1'b0;
    logic [15:0] tx_data = '0;
    logic        tx_cd = 1'b0;
    logic        tx_busy, tx_done, tx_ovf, tx_fail, tx_p, tx_n;

    mkio_transmitter #(.HALF_BIT(H), .MAX_WORDS(33)) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_cd    (tx_cd),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .tx_ovf   (tx_ovf),
        .tx_fail  (tx_fail),
        .tx_p     (tx_p),
        .tx_n     (tx_n)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic p_s[NMAX], n_s[NMAX], done_s[NMAX], busy_s[NMAX], ovf_s[NMAX], fail_s[NMAX];

    int          st_idx[40];
    logic [15:0] st_data[40];
    logic        st_cd[40];
    int          st_n;
    int          rst_at;

    typedef struct {
        logic [15:0] data;
        logic        cd;
        logic [5:0]  sync;
        logic        par;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    task automatic clear_stim();
        st_n   = 0;
        rst_at = -1;
    endtask

    task automatic add_strobe(input int idx, input logic [15:0] d, input logic cd);
        st_idx[st_n]  = idx;
        st_data[st_n] = d;
        st_cd[st_n]   = cd;
        st_n++;
    endtask

    // Sample at each falling edge, then drive the stimulus scheduled for that index.
    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            p_s[i]    = tx_p;
            n_s[i]    = tx_n;
            done_s[i] = tx_done;
            busy_s[i] = tx_busy;
            ovf_s[i]  = tx_ovf;
            fail_s[i] = tx_fail;
            tx_ready  = 1'b0;
            for (int k = 0; k < st_n; k++) begin
                if (st_idx[k] == i) begin
                    tx_ready = 1'b1;
                    tx_data  = st_data[k];
                    tx_cd    = st_cd[k];
                end
            end
            if (i == rst_at) reset = 1'b1;
            else if (i == rst_at + 1) reset = 1'b0;
        end
        tx_ready = 1'b0;
    endtask

    function automatic int cnt(input int which, input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++) begin
            case (which)
                SigP:    c += (p_s[i] === 1'b1) ? 1 : 0;
                SigN:    c += (n_s[i] === 1'b1) ? 1 : 0;
                SigDone: c += (done_s[i] === 1'b1) ? 1 : 0;
                SigBusy: c += (busy_s[i] === 1'b1) ? 1 : 0;
                SigOvf:  c += (ovf_s[i] === 1'b1) ? 1 : 0;
                default: c += (fail_s[i] === 1'b1) ? 1 : 0;
            endcase
        end
        return c;
    endfunction

    function automatic logic lvl(input int base, input int j);
        return p_s[base + j * H + H / 2];
    endfunction

    task automatic check_word(input string tag, input int base, input logic [15:0] exp_data,
                              input logic [5:0] exp_sync, input logic exp_par);
        logic [5:0]  s;
        logic [15:0] d;
        int          bad;
        for (int j = 0; j < 6; j++) s[5 - j] = lvl(base, j);
        for (int k = 0; k < 16; k++) d[15 - k] = lvl(base, 6 + 2 * k);
        bad = 0;
        for (int j = 0; j < 40; j++) begin
            for (int t = 0; t < H; t++) begin
                if (p_s[base + j * H + t] !== lvl(base, j)) bad++;
                if (n_s[base + j * H + t] !== ~p_s[base + j * H + t]) bad++;
            end
        end
        for (int j = 6; j < 40; j += 2) begin
            if (lvl(base, j + 1) !== ~lvl(base, j)) bad++;
        end
        check({tag, " sync"}, 32'(s), 32'(exp_sync));
        check({tag, " data"}, 32'(d), 32'(exp_data));
        check({tag, " parity"}, 32'(lvl(base, 38)), 32'(exp_par));
        check({tag, " shape"}, 32'(bad), 0);
    endtask

    initial begin
        vecs[0] = '{data: 16'h0C65, cd: 1'b0, sync: 6'b111000, par: 1'b1};
        vecs[1] = '{data: 16'hFFFF, cd: 1'b1, sync: 6'b000111, par: 1'b1};
        vecs[2] = '{data: 16'hA5A4, cd: 1'b0, sync: 6'b111000, par: 1'b0};
        vecs[3] = '{data: 16'h0001, cd: 1'b1, sync: 6'b000111, par: 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset lines", {30'd0, tx_p, tx_n}, 0);
        check("reset busy", 32'(tx_busy), 0);
        check("reset done", 32'(tx_done), 0);
        check("reset ovf", 32'(tx_ovf), 0);
        check("reset fail", 32'(tx_fail), 0);

        // Single words: strobe at sample 0, word occupies samples 1..160.
        for (int v = 0; v < 4; v++) begin
            clear_stim();
            add_strobe(0, vecs[v].data, vecs[v].cd);
            capture(170);
            check_word($sformatf("word%0d", v), 1, vecs[v].data, vecs[v].sync, vecs[v].par);
            check($sformatf("word%0d busy", v), 32'(cnt(SigBusy, 1, 160)), 160);
            check($sformatf("word%0d idle", v),
                  32'(cnt(SigP, 161, 169) + cnt(SigN, 161, 169) + cnt(SigBusy, 161, 169)), 0);
            check($sformatf("word%0d done", v),
                  32'(cnt(SigDone, 0, 169) == 1 && done_s[161] === 1'b1), 1);
        end

        // Back-to-back: second strobe at hb=20 of the first word.
        clear_stim();
        add_strobe(0, 16'h0C65, 1'b0);
        add_strobe(81, 16'h0000, 1'b1);
        capture(340);
        check_word("b2b first", 1, 16'h0C65, 6'b111000, 1'b1);
        check_word("b2b second", 161, 16'h0000, 6'b000111, 1'b1);
        check("b2b busy", 32'(cnt(SigBusy, 1, 320)), 320);
        check("b2b busy end", 32'(busy_s[321]), 0);
        check("b2b done", 32'(cnt(SigDone, 0, 339) == 2 && done_s[161] && done_s[321]), 1);

        // Third strobe while holding register is full is dropped.
        clear_stim();
        add_strobe(0, 16'h1234, 1'b0);
        add_strobe(81, 16'h5678, 1'b1);
        add_strobe(100, 16'h9ABC, 1'b0);
        capture(360);
        check_word("ovf first", 1, 16'h1234, 6'b111000, 1'b0);
        check_word("ovf second", 161, 16'h5678, 6'b000111, 1'b1);
        check("ovf pulse", 32'(cnt(SigOvf, 0, 359) == 1 && ovf_s[101] === 1'b1), 1);
        check("ovf words", 32'(cnt(SigDone, 0, 359)), 2);
        check("ovf idle", 32'(cnt(SigP, 321, 359) + cnt(SigN, 321, 359)), 0);

        // Reset at hb=15 with a word held: everything stops, nothing resumes.
        clear_stim();
        add_strobe(0, 16'hBEEF, 1'b0);
        add_strobe(40, 16'h1111, 1'b1);
        rst_at = 61;
        capture(340);
        check("rst pre busy", 32'(busy_s[61]), 1);
        check("rst lines", 32'(cnt(SigP, 62, 339) + cnt(SigN, 62, 339)), 0);
        check("rst busy", 32'(cnt(SigBusy, 62, 339)), 0);
        check("rst done", 32'(cnt(SigDone, 0, 339)), 0);

`ifdef MKIO_TX_FAILSAFE_EN
        // 34 contiguous strobes: 33 words go out, then the fail-safe trips.
        clear_stim();
        add_strobe(0, 16'd0, 1'b1);
        for (int k = 0; k < 33; k++) add_strobe(81 + 160 * k, 16'(k + 1), 1'b1);
        add_strobe(5300, 16'hAAAA, 1'b0);
        capture(5320);
        check_word("fs last", 5121, 16'h0020, 6'b000111, 1'b0);
        check("fs words", 32'(cnt(SigDone, 0, 5319)), 33);
        check("fs fail before", 32'(fail_s[5280]), 0);
        check("fs fail set", 32'(cnt(SigFail, 5281, 5319)), 39);
        check("fs idle", 32'(cnt(SigP, 5281, 5319) + cnt(SigN, 5281, 5319)), 0);
        check("fs busy", 32'(cnt(SigBusy, 5281, 5319)), 0);
        check("fs ovf", 32'(cnt(SigOvf, 0, 5319) == 1 && ovf_s[5301] === 1'b1), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("fs fail cleared", 32'(tx_fail), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
